// File: rtl/stage5_lane_sched_pkg.sv
// Shared widths, codes and state type for the stage-5 lane scheduler.
// Counterpart of the para_def.v defines used by the stage-5 extractors.
package stage5_lane_sched_pkg;

  localparam int MAX_MESSAGE_BITS          = 32;
  localparam int MESSAGE_MUX_CONTROL_WIDTH = 4;
  localparam int N_TYPE_CONTROL_WIDTH      = 3;

  localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_N    = 4'd3;
  // No extractor decodes this code, so an idle lane yields the default output.
  localparam logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] MESSAGE_MUX_IDLE = 4'hF;
  localparam logic [N_TYPE_CONTROL_WIDTH-1:0]      N_TYPE_M         = 3'd2;
  localparam logic [MAX_MESSAGE_BITS-1:0]          DEFAUT_INFOR     = 32'h0000_0000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_ISSUE   = 1'b1
  } sched_state_t;

endpackage

// File: rtl/stage5_lane_reg.sv
// One scheduler lane: captures a message with its mux/subtype codes,
// and returns to the idle code with a zero body when the batch retires.
module stage5_lane_reg
  import stage5_lane_sched_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load,
  input  logic                                 clear,
  input  logic [MAX_MESSAGE_BITS-1:0]          cap_message,
  input  logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] cap_mux,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0]      cap_ntype,
  output logic [MAX_MESSAGE_BITS-1:0]          message,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] mux_ctrl,
  output logic [N_TYPE_CONTROL_WIDTH-1:0]      ntype
);

  // Lane contents: clear has priority, although it never coincides with load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      message  <= '0;
      mux_ctrl <= MESSAGE_MUX_IDLE;
      ntype    <= '0;
    end else if (clear) begin
      message  <= '0;
      mux_ctrl <= MESSAGE_MUX_IDLE;
      ntype    <= '0;
    end else if (load) begin
      message  <= cap_message;
      mux_ctrl <= cap_mux;
      ntype    <= cap_ntype;
    end
  end

endmodule

// File: rtl/stage5_lane_sched.sv
// Packs up to three stage-4 messages into the stage-5 extractor lanes and
// holds each batch until stage 6 accepts it; partial batches leave on timeout or flush.
module stage5_lane_sched
  import stage5_lane_sched_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 16,
  parameter int BATCH_CNT_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [MAX_MESSAGE_BITS-1:0]          in_message,
  input  logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] in_mux_ctrl,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0]      in_ntype,
  input  logic                                 flush,
  input  logic                                 out_ready,
  output logic                                 message_en,
  output logic [MAX_MESSAGE_BITS-1:0]          message_1,
  output logic [MAX_MESSAGE_BITS-1:0]          message_2,
  output logic [MAX_MESSAGE_BITS-1:0]          message_3,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m1,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m2,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m3,
  output logic [N_TYPE_CONTROL_WIDTH-1:0]      N_type_control_m1,
  output logic [N_TYPE_CONTROL_WIDTH-1:0]      N_type_control_m2,
  output logic [N_TYPE_CONTROL_WIDTH-1:0]      N_type_control_m3,
  output logic [1:0]                           lanes_used,
  output logic [BATCH_CNT_W-1:0]               batch_cnt
);

  sched_state_t           state_r, state_next_s;
  logic [1:0]             fill_r, fill_next_s;
  logic [7:0]             timer_r, timer_next_s;
  logic                   en_r, en_next_s;
  logic [1:0]             used_r, used_next_s;
  logic [BATCH_CNT_W-1:0] cnt_r, cnt_next_s;
  logic                   accept_s;
  logic                   clear_s;
  logic                   timeout_s;
  logic [2:0]             load_s;

  logic [MAX_MESSAGE_BITS-1:0]          lane_msg_s [3];
  logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] lane_mux_s [3];
  logic [N_TYPE_CONTROL_WIDTH-1:0]      lane_nt_s  [3];

  assign in_ready  = (state_r == ST_COLLECT);
  assign accept_s  = in_valid && in_ready;
  assign timeout_s = (timer_r == 8'(FLUSH_TIMEOUT - 1));

  // The next free lane (arrival order) takes the accepted message.
  always_comb begin
    load_s = 3'b000;
    if (accept_s) begin
      case (fill_r)
        2'd0:    load_s = 3'b001;
        2'd1:    load_s = 3'b010;
        2'd2:    load_s = 3'b100;
        default: load_s = 3'b000;
      endcase
    end else begin
      load_s = 3'b000;
    end
  end

  // Next-state: collect, then issue on full batch, flush or idle timeout.
  always_comb begin
    state_next_s = state_r;
    fill_next_s  = fill_r;
    timer_next_s = timer_r;
    en_next_s    = en_r;
    used_next_s  = used_r;
    cnt_next_s   = cnt_r;
    clear_s      = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (accept_s) begin
          // An accepted message beats a coincident timeout; flush still issues.
          fill_next_s  = fill_r + 2'd1;
          timer_next_s = 8'd0;
          if ((fill_r == 2'd2) || flush) begin
            state_next_s = ST_ISSUE;
            en_next_s    = 1'b1;
            used_next_s  = fill_r + 2'd1;
          end else begin
            state_next_s = ST_COLLECT;
          end
        end else if (fill_r == 2'd0) begin
          timer_next_s = 8'd0;
        end else if (flush || timeout_s) begin
          state_next_s = ST_ISSUE;
          en_next_s    = 1'b1;
          used_next_s  = fill_r;
          timer_next_s = 8'd0;
        end else begin
          timer_next_s = timer_r + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          state_next_s = ST_COLLECT;
          fill_next_s  = 2'd0;
          timer_next_s = 8'd0;
          en_next_s    = 1'b0;
          used_next_s  = 2'd0;
          cnt_next_s   = cnt_r + BATCH_CNT_W'(1);
          clear_s      = 1'b1;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      default: begin
        state_next_s = ST_COLLECT;
        fill_next_s  = 2'd0;
        timer_next_s = 8'd0;
        en_next_s    = 1'b0;
        used_next_s  = 2'd0;
        clear_s      = 1'b1;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_COLLECT;
      fill_r  <= 2'd0;
      timer_r <= 8'd0;
      en_r    <= 1'b0;
      used_r  <= 2'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      fill_r  <= fill_next_s;
      timer_r <= timer_next_s;
      en_r    <= en_next_s;
      used_r  <= used_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    stage5_lane_reg u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load_s[i]),
      .clear       (clear_s),
      .cap_message (in_message),
      .cap_mux     (in_mux_ctrl),
      .cap_ntype   (in_ntype),
      .message     (lane_msg_s[i]),
      .mux_ctrl    (lane_mux_s[i]),
      .ntype       (lane_nt_s[i])
    );
  end

  assign message_en             = en_r;
  assign lanes_used             = used_r;
  assign batch_cnt              = cnt_r;
  assign message_1              = lane_msg_s[0];
  assign message_2              = lane_msg_s[1];
  assign message_3              = lane_msg_s[2];
  assign message_mux_control_m1 = lane_mux_s[0];
  assign message_mux_control_m2 = lane_mux_s[1];
  assign message_mux_control_m3 = lane_mux_s[2];
  assign N_type_control_m1      = lane_nt_s[0];
  assign N_type_control_m2      = lane_nt_s[1];
  assign N_type_control_m3      = lane_nt_s[2];

endmodule

// File: tb/tb_stage5_lane_sched.sv
// Bench for stage5_lane_sched: directed batches plus random traffic against
// a queue-based model of the pending batch.
module tb_stage5_lane_sched;
  import stage5_lane_sched_pkg::*;

  localparam int TO   = 16;
  localparam int MW   = MAX_MESSAGE_BITS;
  localparam int MUXW = MESSAGE_MUX_CONTROL_WIDTH;
  localparam int NTW  = N_TYPE_CONTROL_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [MW-1:0]   in_message = '0;
  logic [MUXW-1:0] in_mux_ctrl = '0;
  logic [NTW-1:0]  in_ntype = '0;
  logic            in_ready;
  logic            message_en;
  logic [MW-1:0]   message_1, message_2, message_3;
  logic [MUXW-1:0] mux_m1, mux_m2, mux_m3;
  logic [NTW-1:0]  nt_m1, nt_m2, nt_m3;
  logic [1:0]      lanes_used;
  logic [15:0]     batch_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [MW-1:0]   msg;
    logic [MUXW-1:0] mux;
    logic [NTW-1:0]  nt;
  } ent_t;

  // Model: the pending batch is a queue in arrival order.
  ent_t        q[$];
  bit          m_issue = 1'b0;
  int          m_idle = 0;
  logic [15:0] m_cnt = 16'd0;

  stage5_lane_sched #(.FLUSH_TIMEOUT(TO), .BATCH_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_message(in_message), .in_mux_ctrl(in_mux_ctrl), .in_ntype(in_ntype),
    .flush(flush), .out_ready(out_ready), .message_en(message_en),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(mux_m1), .message_mux_control_m2(mux_m2),
    .message_mux_control_m3(mux_m3),
    .N_type_control_m1(nt_m1), .N_type_control_m2(nt_m2), .N_type_control_m3(nt_m3),
    .lanes_used(lanes_used), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [MW-1:0] m, input logic [MUXW-1:0] x, input logic [NTW-1:0] n);
    in_valid    = 1'b1;
    in_message  = m;
    in_mux_ctrl = x;
    in_ntype    = n;
    step();
    in_valid    = 1'b0;
  endtask

  // Model update: one decision per clock edge, cleared by reset at once.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_issue = 1'b0;
        m_idle  = 0;
        m_cnt   = 16'd0;
      end else if (m_issue) begin
        if (out_ready) begin
          q.delete();
          m_issue = 1'b0;
          m_idle  = 0;
          m_cnt   = m_cnt + 16'd1;
        end
      end else if (in_valid) begin
        q.push_back('{msg: in_message, mux: in_mux_ctrl, nt: in_ntype});
        m_idle = 0;
        if (q.size() == 3 || flush) m_issue = 1'b1;
      end else if (q.size() > 0) begin
        m_idle++;
        if (flush || m_idle == TO) m_issue = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [MW-1:0]   em [3];
    logic [MUXW-1:0] ex [3];
    logic [NTW-1:0]  en [3];
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (i < q.size()) begin
          em[i] = q[i].msg; ex[i] = q[i].mux; en[i] = q[i].nt;
        end else begin
          em[i] = '0; ex[i] = MESSAGE_MUX_IDLE; en[i] = '0;
        end
      end
      chk("in_ready", 64'(in_ready), 64'(!m_issue));
      chk("message_en", 64'(message_en), 64'(m_issue));
      chk("lanes_used", 64'(lanes_used), m_issue ? 64'(q.size()) : 64'd0);
      chk("batch_cnt", 64'(batch_cnt), 64'(m_cnt));
      chk("message_1", 64'(message_1), 64'(em[0]));
      chk("message_2", 64'(message_2), 64'(em[1]));
      chk("message_3", 64'(message_3), 64'(em[2]));
      chk("mux_m1", 64'(mux_m1), 64'(ex[0]));
      chk("mux_m2", 64'(mux_m2), 64'(ex[1]));
      chk("mux_m3", 64'(mux_m3), 64'(ex[2]));
      chk("ntype_m1", 64'(nt_m1), 64'(en[0]));
      chk("ntype_m2", 64'(nt_m2), 64'(en[1]));
      chk("ntype_m3", 64'(nt_m3), 64'(en[2]));
    end
  end

  initial begin
    int k;
    int pv;
    logic [15:0] cnt0;
    #1 rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_en", 64'(message_en), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", 64'(batch_cnt), 64'd0);
    chk("rst_mux1", 64'(mux_m1), 64'(MESSAGE_MUX_IDLE));

    // Back-to-back full batch with out_ready held high.
    out_ready = 1'b1;
    send(32'hA1A1_0001, MESSAGE_MUX_N, N_TYPE_M);
    send(32'hB2B2_0002, MESSAGE_MUX_N, N_TYPE_M);
    send(32'hC3C3_0003, MESSAGE_MUX_N, N_TYPE_M);
    chk("t1_en", 64'(message_en), 64'd1);
    chk("t1_msg1", 64'(message_1), 64'h0000_0000_A1A1_0001);
    chk("t1_msg3", 64'(message_3), 64'h0000_0000_C3C3_0003);
    chk("t1_used", 64'(lanes_used), 64'd3);
    chk("t1_mux2", 64'(mux_m2), 64'd3);
    chk("t1_nt1", 64'(nt_m1), 64'd2);
    step();
    chk("t1_en_drop", 64'(message_en), 64'd0);
    chk("t1_cnt", 64'(batch_cnt), 64'd1);

    // Single message issued by timeout.
    out_ready = 1'b0;
    send(32'h0000_00AA, 4'd1, 3'd1);
    k = 0;
    while (k < 40 && !message_en) begin
      step();
      k++;
    end
    chk("t2_latency", 64'(k), 64'd16);
    chk("t2_used", 64'(lanes_used), 64'd1);
    chk("t2_msg1", 64'(message_1), 64'h0000_0000_0000_00AA);
    chk("t2_mux2", 64'(mux_m2), 64'(MESSAGE_MUX_IDLE));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Full batch held by back-pressure while upstream keeps offering.
    send(32'hD000_0004, 4'd2, 3'd3);
    send(32'hE000_0005, 4'd4, 3'd4);
    send(32'hF000_0006, 4'd5, 3'd5);
    cnt0 = batch_cnt;
    in_valid   = 1'b1;
    in_message = 32'h7777_7777;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_en", 64'(message_en), 64'd1);
      chk("t3_hold_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_msg1", 64'(message_1), 64'h0000_0000_D000_0004);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_cnt_once", 64'(batch_cnt), 64'(cnt0) + 64'd1);

    // Third accept lands exactly on the timeout cycle.
    send(32'h1111_0007, 4'd6, 3'd6);
    send(32'h2222_0008, 4'd7, 3'd7);
    repeat (15) step();
    chk("t4_no_early", 64'(message_en), 64'd0);
    send(32'h3333_0009, 4'd8, 3'd0);
    chk("t4_en", 64'(message_en), 64'd1);
    chk("t4_used", 64'(lanes_used), 64'd3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush while empty is ignored; flush with the second accept issues two lanes.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_empty_flush", 64'(message_en), 64'd0);
    send(32'h4444_000A, 4'd9, 3'd1);
    flush = 1'b1;
    send(32'h5555_000B, 4'd10, 3'd2);
    flush = 1'b0;
    chk("t5_en", 64'(message_en), 64'd1);
    chk("t5_used", 64'(lanes_used), 64'd2);
    chk("t5_msg2", 64'(message_2), 64'h0000_0000_5555_000B);
    chk("t5_mux3", 64'(mux_m3), 64'(MESSAGE_MUX_IDLE));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the middle of an issued batch.
    send(32'h6666_000C, 4'd1, 3'd1);
    send(32'h6666_000D, 4'd1, 3'd1);
    send(32'h6666_000E, 4'd1, 3'd1);
    chk("t6_pre_en", 64'(message_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 64'(message_en), 64'd0);
    chk("t6_rst_mux1", 64'(mux_m1), 64'(MESSAGE_MUX_IDLE));
    chk("t6_rst_msg1", 64'(message_1), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_cnt", 64'(batch_cnt), 64'd0);
    chk("t6_msg1", 64'(message_1), 64'd0);
    chk("t6_en", 64'(message_en), 64'd0);

    // Random traffic in segments of differing upstream density.
    pv = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(3))
          0:       pv = 0;
          1:       pv = 10;
          2:       pv = 60;
          default: pv = 95;
        endcase
      end
      in_valid    = ($urandom_range(99) < pv);
      flush       = ($urandom_range(99) < 4);
      out_ready   = ($urandom_range(99) < 50);
      in_message  = $urandom();
      in_mux_ctrl = MUXW'($urandom_range(15));
      in_ntype    = NTW'($urandom_range(7));
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
